// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage of the 8-bit RISC core.
// Selects the writeback value, commits it to the general register file,
// serves the two decode read ports with optional write-through bypass, and
// keeps a saturating retired-write counter plus a last-write trace.
module wb_regfile #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter bit          R0_ZERO = 1'b1,
    parameter bit          BYPASS  = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit,
    output logic [ADDR_W-1:0] last_rd,
    output logic [DATA_W-1:0] last_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [ADDR_W-1:0] last_rd_q, last_rd_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic              rd_is_r0;

    // Writeback value mux, driven regardless of the write enable
    always_comb begin
        wb_data = wb_alu_result;
        if (wb_mem_to_reg) begin
            wb_data = wb_mem_data;
        end
    end

    // Commit qualifier: suppressed during reset and for hardwired-zero R0
    always_comb begin
        rd_is_r0  = (R0_ZERO != 1'b0) && (wb_rd == '0);
        wb_commit = wb_reg_write && !reset && !rd_is_r0;
    end

    // Next-state for storage, trace and saturating counter
    always_comb begin
        regs_d      = regs_q;
        last_rd_d   = last_rd_q;
        last_data_d = last_data_q;
        wr_count_d  = wr_count_q;
        if (wb_commit) begin
            regs_d[wb_rd] = wb_data;
            last_rd_d     = wb_rd;
            last_data_d   = wb_data;
            if (wr_count_q != {CNT_W{1'b1}}) begin
                wr_count_d = wr_count_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            last_rd_q   <= '0;
            last_data_q <= '0;
            wr_count_q  <= '0;
        end else begin
            regs_q      <= regs_d;
            last_rd_q   <= last_rd_d;
            last_data_q <= last_data_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Read port 1: R0 zero, then same-cycle bypass, then stored value
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if ((BYPASS != 1'b0) && wb_commit && (rs1_addr == wb_rd)) begin
            rs1_data = wb_data;
        end
        if ((R0_ZERO != 1'b0) && (rs1_addr == '0)) begin
            rs1_data = '0;
        end
    end

    // Read port 2: identical rules to port 1, independent address
    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if ((BYPASS != 1'b0) && wb_commit && (rs2_addr == wb_rd)) begin
            rs2_data = wb_data;
        end
        if ((R0_ZERO != 1'b0) && (rs2_addr == '0)) begin
            rs2_data = '0;
        end
    end

    assign last_rd   = last_rd_q;
    assign last_data = last_data_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: two builds share one stimulus stream.
//   dut_a: defaults (R0 hardwired zero, bypass on, 16-bit counter)
//   dut_b: R0 ordinary, bypass off, 4-bit counter (saturation reachable)
module tb_wb_regfile;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wb_mem_data, wb_alu_result;
    logic [2:0] wb_rd, rs1_addr, rs2_addr;
    logic       wb_reg_write, wb_mem_to_reg;

    logic [7:0]  rs1_a, rs2_a, wbd_a, ld_a;
    logic [7:0]  rs1_b, rs2_b, wbd_b, ld_b;
    logic        cm_a, cm_b;
    logic [2:0]  lr_a, lr_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain register arrays and counters
    logic [7:0]  ma [8];
    logic [7:0]  mb [8];
    int unsigned ca, cb;
    logic [2:0]  mlr_a, mlr_b;
    logic [7:0]  mld_a, mld_b;

    always #5 clk = ~clk;

    wb_regfile dut_a (
        .clk(clk), .reset(reset),
        .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_a), .rs2_data(rs2_a), .wb_data(wbd_a), .wb_commit(cm_a),
        .last_rd(lr_a), .last_data(ld_a), .wr_count(cnt_a)
    );

    wb_regfile #(.R0_ZERO(1'b0), .BYPASS(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_b), .rs2_data(rs2_b), .wb_data(wbd_b), .wb_commit(cm_b),
        .last_rd(lr_b), .last_data(ld_b), .wr_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_wbd();
        return wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    endfunction

    function automatic logic exp_commit_a();
        return wb_reg_write && !reset && (wb_rd != 3'd0);
    endfunction

    function automatic logic exp_commit_b();
        return wb_reg_write && !reset;
    endfunction

    // Build A view: R0 reads zero, pending write forwarded
    function automatic logic [7:0] read_a(input logic [2:0] addr);
        if (addr == 3'd0) return 8'h00;
        if (exp_commit_a() && addr == wb_rd) return exp_wbd();
        return ma[addr];
    endfunction

    // Build B view: stored value only
    function automatic logic [7:0] read_b(input logic [2:0] addr);
        return mb[addr];
    endfunction

    task automatic check_comb(input string ph);
        chk({ph, "_wbd_a"}, 32'(wbd_a), 32'(exp_wbd()));
        chk({ph, "_wbd_b"}, 32'(wbd_b), 32'(exp_wbd()));
        chk({ph, "_cm_a"}, 32'(cm_a), 32'(exp_commit_a()));
        chk({ph, "_cm_b"}, 32'(cm_b), 32'(exp_commit_b()));
        chk({ph, "_rs1_a"}, 32'(rs1_a), 32'(read_a(rs1_addr)));
        chk({ph, "_rs2_a"}, 32'(rs2_a), 32'(read_a(rs2_addr)));
        chk({ph, "_rs1_b"}, 32'(rs1_b), 32'(read_b(rs1_addr)));
        chk({ph, "_rs2_b"}, 32'(rs2_b), 32'(read_b(rs2_addr)));
    endtask

    task automatic check_regs(input string ph);
        chk({ph, "_lrd_a"}, 32'(lr_a), 32'(mlr_a));
        chk({ph, "_ldat_a"}, 32'(ld_a), 32'(mld_a));
        chk({ph, "_cnt_a"}, 32'(cnt_a), ca);
        chk({ph, "_lrd_b"}, 32'(lr_b), 32'(mlr_b));
        chk({ph, "_ldat_b"}, 32'(ld_b), 32'(mld_b));
        chk({ph, "_cnt_b"}, 32'(cnt_b), cb);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
        end
        ca = 0; cb = 0;
        mlr_a = 3'd0; mlr_b = 3'd0;
        mld_a = 8'h00; mld_b = 8'h00;
    endtask

    // One cycle: drive at negedge, check pre-edge, clock, check post-edge
    task automatic step(input logic we, input logic m2r, input logic [2:0] rd,
                        input logic [7:0] md, input logic [7:0] ad,
                        input logic [2:0] r1, input logic [2:0] r2);
        logic       ce_a, ce_b;
        logic [7:0] v;
        wb_reg_write  = we;
        wb_mem_to_reg = m2r;
        wb_rd         = rd;
        wb_mem_data   = md;
        wb_alu_result = ad;
        rs1_addr      = r1;
        rs2_addr      = r2;
        #1;
        check_comb("pre");
        ce_a = exp_commit_a();
        ce_b = exp_commit_b();
        v    = exp_wbd();
        @(posedge clk);
        if (ce_a) begin
            ma[rd] = v; mlr_a = rd; mld_a = v;
            if (ca < 32'hFFFF) ca++;
        end
        if (ce_b) begin
            mb[rd] = v; mlr_b = rd; mld_b = v;
            if (cb < 15) cb++;
        end
        #1;
        check_regs("post");
        check_comb("postrd");
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle with a write pending; held across one edge
    task automatic mid_reset();
        wb_reg_write = 1'b1;
        wb_rd        = 3'd3;
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_cm_a", 32'(cm_a), 32'd0);
        chk("rst_cm_b", 32'(cm_b), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_cnt_b", 32'(cnt_b), 32'd0);
        for (int r = 0; r < 8; r++) begin
            rs1_addr = 3'(r);
            rs2_addr = 3'(7 - r);
            #0.1;
            chk("rst_rs1_a", 32'(rs1_a), 32'd0);
            chk("rst_rs2_b", 32'(rs2_b), 32'd0);
        end
        @(posedge clk);
        #1;
        check_regs("rsthold");
        chk("rsthold_rs_b", 32'(rs1_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        wb_mem_data   = 8'h00;
        wb_alu_result = 8'h00;
        wb_rd         = 3'd0;
        wb_reg_write  = 1'b0;
        wb_mem_to_reg = 1'b0;
        rs1_addr      = 3'd1;
        rs2_addr      = 3'd2;
        model_clear();
        #1;
        check_comb("reset");
        check_regs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ALU-path write to R3, then read back
        step(1'b1, 1'b0, 3'd3, 8'hA5, 8'h5A, 3'd3, 3'd0);
        step(1'b0, 1'b0, 3'd1, 8'h00, 8'h00, 3'd3, 3'd3);
        chk("t1_rs1", 32'(rs1_a), 32'h5A);
        chk("t1_cnt", 32'(cnt_a), 32'd1);
        chk("t1_lrd", 32'(lr_a), 32'd3);
        chk("t1_ldat", 32'(ld_a), 32'h5A);

        // Load path selects memory data
        step(1'b1, 1'b1, 3'd5, 8'hC3, 8'h11, 3'd5, 3'd5);
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd5, 3'd1);
        chk("t2_rs1", 32'(rs1_a), 32'hC3);

        // Same-cycle bypass on both ports; build B shows old value
        step(1'b1, 1'b0, 3'd2, 8'h00, 8'h7E, 3'd2, 3'd2);
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd2, 3'd2);
        chk("t3_rs2_b", 32'(rs2_b), 32'h7E);

        // R0 write dropped in build A, ordinary in build B
        step(1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 3'd0, 3'd0);
        chk("t4_r0_a", 32'(rs1_a), 32'h00);
        chk("t4_cnt_a", 32'(cnt_a), 32'd3);

        // Disabled write changes nothing, then async reset mid-cycle
        step(1'b0, 1'b0, 3'd4, 8'h00, 8'h99, 3'd4, 3'd4);
        chk("t5_r4", 32'(rs1_a), 32'h00);
        mid_reset();

        // Saturation of the 4-bit counter in build B
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'(i & 1), 3'(i + 1), 8'(i * 7), 8'(i * 13), 3'(i), 3'(i + 1));
        end
        chk("t6_sat_b", 32'(cnt_b), 32'd15);

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [2:0] rd;
            logic [2:0] r1, r2;
            rd = 3'($urandom);
            r1 = ($urandom_range(3) == 0) ? rd : 3'($urandom);
            r2 = ($urandom_range(3) == 0) ? rd : 3'($urandom);
            step(1'($urandom_range(3) != 0), 1'($urandom), rd,
                 8'($urandom), 8'($urandom), r1, r2);
            if ($urandom_range(60) == 0) mid_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
